// File: rtl/aes_roundkey.sv
// Combinational AES key-schedule step: derives the next four schedule words
// from the previous round key.
//   mode        : 2'b00 rotate+sub+rcon (AES-128 step), 2'b01 sub only,
//                 2'b1x pass current_key through
//   RD          : round number, selects the round constant (1..10)
//   prev_key    : words w[i-4..i-1] that the new words are chained onto
//   current_key : source of the last word fed through SubWord
//   round_key   : next 128-bit round key
module aes_roundkey (
  input  logic [1:0]   mode,
  input  logic [3:0]   RD,
  input  logic [127:0] prev_key,
  input  logic [127:0] current_key,
  output logic [127:0] round_key
);

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte x lives at bit offset 8*(255-x), i.e. {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [7:0]  rcon_c;
  logic [31:0] last_c, temp_c, w0_c, w1_c, w2_c, w3_c;

  // Round constant per round number.
  always_comb begin
    rcon_c = 8'h00;
    unique case (RD)
      4'd1:    rcon_c = 8'h01;
      4'd2:    rcon_c = 8'h02;
      4'd3:    rcon_c = 8'h04;
      4'd4:    rcon_c = 8'h08;
      4'd5:    rcon_c = 8'h10;
      4'd6:    rcon_c = 8'h20;
      4'd7:    rcon_c = 8'h40;
      4'd8:    rcon_c = 8'h80;
      4'd9:    rcon_c = 8'h1b;
      4'd10:   rcon_c = 8'h36;
      default: rcon_c = 8'h00;
    endcase
  end

  // Word chaining: each new word is the old word xor the new word before it.
  always_comb begin
    last_c = current_key[31:0];
    temp_c = 32'h0;
    unique case (mode)
      2'b00:   temp_c = sub_word({last_c[23:0], last_c[31:24]}) ^ {rcon_c, 24'h0};
      2'b01:   temp_c = sub_word(last_c);
      default: temp_c = 32'h0;
    endcase
    w0_c = prev_key[127:96] ^ temp_c;
    w1_c = prev_key[95:64]  ^ w0_c;
    w2_c = prev_key[63:32]  ^ w1_c;
    w3_c = prev_key[31:0]   ^ w2_c;
    round_key = mode[1] ? current_key : {w0_c, w1_c, w2_c, w3_c};
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key expansion: accepts a cipher key, iterates one
// key-schedule step per cycle into an 11-entry round-key buffer, and serves
// the buffer through a registered indexed read port.
//   clk, rst     : clock, synchronous active-high reset
//   key_in       : cipher key, captured when key_valid && key_ready
//   key_valid    : key_in valid
//   key_ready    : a key can be accepted (IDLE or DONE)
//   busy         : expansion in progress
//   keys_valid   : rk[0..10] all hold the current key's schedule
//   rd_idx       : round-key index to read; 11..15 read as zero
//   rd_key       : rk[rd_idx], one cycle after rd_idx
module aes_key_expand_seq #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam int unsigned NUM_RK = NR + 1;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned KEY_W  = 128;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rnd_q, rnd_d;
  logic [KEY_W-1:0]   rk_q [NUM_RK];
  logic [KEY_W-1:0]   rk_d [NUM_RK];
  logic [KEY_W-1:0]   rd_key_q, rd_key_d;
  logic               key_ready_q, key_ready_d;
  logic               busy_q, busy_d;
  logic               keys_valid_q, keys_valid_d;

  logic [IDX_W-1:0]   prev_idx_c;
  logic [KEY_W-1:0]   prev_key_c;
  logic [KEY_W-1:0]   round_key_c;

  // Select rk[rnd-1]; clamped so an idle rnd of 0 never indexes outside the buffer.
  always_comb begin
    prev_idx_c = (rnd_q == '0) ? '0 : rnd_q - IDX_W'(1);
    prev_key_c = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (IDX_W'(i) == prev_idx_c) prev_key_c = rk_q[i];
    end
  end

  aes_roundkey u_roundkey (
    .mode        (2'b00),
    .RD          (rnd_q),
    .prev_key    (prev_key_c),
    .current_key (prev_key_c),
    .round_key   (round_key_c)
  );

  // Next-state, buffer update and read-port logic.
  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    rk_d     = rk_q;
    rd_key_d = '0;

    // Reads use the pre-edge buffer, so a same-edge write is not visible yet.
    for (int i = 0; i < NUM_RK; i++) begin
      if (IDX_W'(i) == rd_idx) rd_key_d = rk_q[i];
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (key_valid) begin
          rk_d[0] = key_in;
          rnd_d   = IDX_W'(1);
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        for (int i = 1; i < NUM_RK; i++) begin
          if (IDX_W'(i) == rnd_q) rk_d[i] = round_key_c;
        end
        // rnd holds at NR after the last round; only an accept reloads it.
        if (rnd_q == IDX_W'(NR)) begin
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    key_ready_d  = (state_d != EXPAND);
    busy_d       = (state_d == EXPAND);
    keys_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rnd_q        <= '0;
      rd_key_q     <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      rd_key_q     <= rd_key_d;
      key_ready_q  <= key_ready_d;
      busy_q       <= busy_d;
      keys_valid_q <= keys_valid_d;
      for (int i = 0; i < NUM_RK; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign key_ready  = key_ready_q;
  assign busy       = busy_q;
  assign keys_valid = keys_valid_q;
  assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: FIPS-197 vectors, handshake,
// reset, back-to-back and read-port corner cases, then random keys against a
// software key-expansion model built from GF(2^8) arithmetic.
module tb_aes_key_expand_seq;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  aes_key_expand_seq #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_RK1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_RK10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  // ---------------- reference model ----------------
  logic [7:0]   sb [256];
  logic [127:0] model_rk [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse, then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!key_ready && guard < 40) begin
      tick();
      guard++;
    end
    chk("ready_timeout", 128'(key_ready), 128'd1);
  endtask

  // Accept a key, then check busy/keys_valid cycle by cycle up to DONE.
  task automatic expand(input logic [127:0] key);
    wait_ready();
    key_in    = key;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      chk("exp_busy", 128'(busy), 128'd1);
      chk("exp_kv_low", 128'(keys_valid), 128'd0);
      chk("exp_ready_nbusy", 128'(key_ready), 128'(!busy));
      tick();
    end
    chk("done_busy", 128'(busy), 128'd0);
    chk("done_kv", 128'(keys_valid), 128'd1);
    chk("done_ready", 128'(key_ready), 128'd1);
  endtask

  task automatic read_all(input logic [127:0] key, input string name);
    model_expand(key);
    for (int r = 0; r < 11; r++) begin
      rd_idx = 4'(r);
      tick();
      chk(name, rd_key, model_rk[r]);
    end
  endtask

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [127:0] cur_key;
    logic [127:0] old_rk3;
    logic [127:0] k3;
    int guard;

    rst       = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rd_idx    = 4'd0;
    build_sbox();

    vecs[0] = '{"fips_rk0",  FIPS_KEY, 4'd0,  FIPS_KEY};
    vecs[1] = '{"fips_rk1",  FIPS_KEY, 4'd1,  FIPS_RK1};
    vecs[2] = '{"fips_rk10", FIPS_KEY, 4'd10, FIPS_RK10};
    vecs[3] = '{"fips_idx11", FIPS_KEY, 4'd11, 128'h0};
    vecs[4] = '{"fips_idx15", FIPS_KEY, 4'd15, 128'h0};
    vecs[5] = '{"k2_rk0",    K2_KEY,   4'd0,  K2_KEY};
    vecs[6] = '{"k2_rk1",    K2_KEY,   4'd1,  K2_RK1};
    vecs[7] = '{"k2_rk10",   K2_KEY,   4'd10, K2_RK10};

    // Reset state
    tick();
    tick();
    chk("rst_ready", 128'(key_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_kv", 128'(keys_valid), 128'd0);
    chk("rst_rdkey", rd_key, 128'h0);
    rst = 1'b0;
    rd_idx = 4'd10;
    tick();
    chk("rst_rk10", rd_key, 128'h0);

    // Model sanity against published FIPS values
    model_expand(FIPS_KEY);
    chk("model_fips_rk10", model_rk[10], FIPS_RK10);

    // Table-driven known-answer vectors
    cur_key = '0;
    for (int v = 0; v < 8; v++) begin
      if (v == 0 || vecs[v].key != cur_key) begin
        expand(vecs[v].key);
        cur_key = vecs[v].key;
      end
      rd_idx = vecs[v].idx;
      tick();
      chk(vecs[v].name, rd_key, vecs[v].exp);
    end

    // Hold-off: K2 held valid through a FIPS expansion, then back-to-back accept
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    rd_idx = 4'd0;
    tick();
    key_in = K2_KEY;
    for (int i = 1; i <= 10; i++) begin
      chk("holdoff_ready_low", 128'(key_ready), 128'd0);
      tick();
    end
    chk("holdoff_kv", 128'(keys_valid), 128'd1);
    chk("holdoff_rk0_kept", rd_key, FIPS_KEY);
    rd_idx = 4'd10;
    tick();
    key_valid = 1'b0;
    chk("b2b_kv_fall", 128'(keys_valid), 128'd0);
    chk("b2b_busy", 128'(busy), 128'd1);
    chk("b2b_rk10_old0", rd_key, FIPS_RK10);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("b2b_rk10_old", rd_key, FIPS_RK10);
    end
    chk("b2b_kv_rise", 128'(keys_valid), 128'd1);
    tick();
    chk("b2b_rk10_new", rd_key, K2_RK10);
    read_all(K2_KEY, "b2b_all");

    // Read-before-write on rk[3]
    model_expand(K2_KEY);
    old_rk3 = model_rk[3];
    k3 = {$urandom, $urandom, $urandom, $urandom};
    rd_idx = 4'd3;
    key_in = k3;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("rbw_old", rd_key, old_rk3);
    tick();
    model_expand(k3);
    chk("rbw_new", rd_key, model_rk[3]);
    guard = 0;
    while (!keys_valid && guard < 20) begin
      tick();
      guard++;
    end
    chk("rbw_done_timeout", 128'(keys_valid), 128'd1);
    read_all(k3, "rbw_all");

    // Reset mid-expansion at E0+5
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_kv", 128'(keys_valid), 128'd0);
    chk("midrst_ready", 128'(key_ready), 128'd1);
    rd_idx = 4'd1;
    tick();
    chk("midrst_rk1", rd_key, 128'h0);
    expand(FIPS_KEY);
    read_all(FIPS_KEY, "midrst_fips");

    // Randomized regression
    for (int n = 0; n < 900; n++) begin
      logic [127:0] k;
      int idle;
      k = {$urandom, $urandom, $urandom, $urandom};
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) tick();
      expand(k);
      read_all(k, "rand_rk");
      if ($urandom_range(0, 7) == 0) begin
        rd_idx = 4'($urandom_range(11, 15));
        tick();
        chk("rand_oob", rd_key, 128'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
